// File: rtl/mat_seq_pkg.sv
// Shared types for the matrix sequencer: state encoding and the
// default PE MAC pipeline depth.
package mat_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_FIN
  } seq_state_t;

  localparam int MAC_LAT_DEF = 2;

endpackage

// File: rtl/mat_seq_ctrl.sv
// Row-by-row matrix multiply sequencer for an N-PE MAC array.
// Ports: CLK/RST (sync, active high), START/ROWS run request,
//   HOLD operand stall, ABORT cancel; BUSY/DONE status,
//   CLR_ACC/MAC_EN/SEQ_A/SEQ_B PE control, WR_ROW/ROW_IDX write-back.
module mat_seq_ctrl
  import mat_seq_pkg::*;
#(
  parameter int N       = 16,
  parameter int LogN    = $clog2(N),
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [LogN-1:0] ROWS,
  input  logic            HOLD,
  input  logic            ABORT,
  output logic            BUSY,
  output logic            DONE,
  output logic            CLR_ACC,
  output logic            MAC_EN,
  output logic [LogN-1:0] SEQ_A,
  output logic [LogN-1:0] SEQ_B,
  output logic            WR_ROW,
  output logic [LogN-1:0] ROW_IDX
);

  localparam logic [LogN-1:0] KMAX = LogN'(N - 1);

  seq_state_t      r_state, w_state_nxt;
  logic [LogN-1:0] r_k, w_k_nxt;
  logic [LogN-1:0] r_row, w_row_nxt;
  logic [LogN-1:0] r_rows, w_rows_nxt;
  logic [2:0]      r_dcnt, w_dcnt_nxt;
  logic            w_en_nxt;

  logic            r_busy, r_done, r_clr, r_mac_en, r_wr;
  logic [LogN-1:0] r_seq, r_row_idx;

  // r_k is the operand index on SEQ_A/B this cycle. A MAC cycle
  // without HOLD advances it; a HOLD edge repeats it as a bubble
  // (MAC_EN=0), so each index is issued with MAC_EN=1 exactly once.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_row_nxt   = r_row;
    w_rows_nxt  = r_rows;
    w_dcnt_nxt  = r_dcnt;
    w_en_nxt    = 1'b0;
    if (ABORT && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_k_nxt     = '0;
      w_row_nxt   = '0;
      w_dcnt_nxt  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (START && !ABORT) begin
            w_state_nxt = S_CLEAR;
            w_rows_nxt  = ROWS;
            w_row_nxt   = '0;
            w_k_nxt     = '0;
          end
        end
        S_CLEAR: begin
          w_state_nxt = S_MAC;
          w_k_nxt     = '0;
          w_en_nxt    = 1'b1;
        end
        S_MAC: begin
          if (HOLD) begin
            w_en_nxt = 1'b0;
          end else if (r_k == KMAX) begin
            w_state_nxt = (MAC_LAT == 0) ? S_WRITE : S_DRAIN;
            w_dcnt_nxt  = '0;
          end else begin
            w_k_nxt  = r_k + LogN'(1);
            w_en_nxt = 1'b1;
          end
        end
        S_DRAIN: begin
          if (int'(r_dcnt) + 1 >= MAC_LAT) begin
            w_state_nxt = S_WRITE;
          end else begin
            w_dcnt_nxt = r_dcnt + 3'd1;
          end
        end
        S_WRITE: begin
          if (r_row < r_rows) begin
            w_row_nxt   = r_row + LogN'(1);
            w_k_nxt     = '0;
            w_state_nxt = S_CLEAR;
          end else begin
            w_state_nxt = S_FIN;
          end
        end
        S_FIN: begin
          w_state_nxt = S_IDLE;
          w_k_nxt     = '0;
          w_row_nxt   = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_row   <= '0;
      r_rows  <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_row   <= w_row_nxt;
      r_rows  <= w_rows_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  // Outputs are registered from the next state so they line up
  // with the state register and never glitch on input changes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_clr     <= 1'b0;
      r_mac_en  <= 1'b0;
      r_wr      <= 1'b0;
      r_seq     <= '0;
      r_row_idx <= '0;
    end else begin
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_FIN);
      r_clr     <= (w_state_nxt == S_CLEAR);
      r_mac_en  <= w_en_nxt;
      r_wr      <= (w_state_nxt == S_WRITE);
      r_seq     <= (w_state_nxt == S_MAC) ? w_k_nxt : '0;
      r_row_idx <= (w_state_nxt == S_IDLE) ? '0 : w_row_nxt;
    end
  end

  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign CLR_ACC = r_clr;
  assign MAC_EN  = r_mac_en;
  assign SEQ_A   = r_seq;
  assign SEQ_B   = r_seq;
  assign WR_ROW  = r_wr;
  assign ROW_IDX = r_row_idx;

endmodule

// File: tb/tb_mat_seq_ctrl.sv
// Directed bench for mat_seq_ctrl: one default instance (MAC_LAT=2)
// and one MAC_LAT=0 instance sharing the clock.
module tb_mat_seq_ctrl;

  logic       CLK;
  logic       rst0, start0, hold0, abort0;
  logic [3:0] rows0;
  logic       busy0, done0, clr0, en0, wr0;
  logic [3:0] seqa0, seqb0, row0;

  logic       rst1, start1, hold1, abort1;
  logic [3:0] rows1;
  logic       busy1, done1, clr1, en1, wr1;
  logic [3:0] seqa1, seqb1, row1;

  int n_checks = 0;
  int n_fail   = 0;

  mat_seq_ctrl #(.N(16), .MAC_LAT(2)) dut0 (
    .CLK(CLK), .RST(rst0), .START(start0), .ROWS(rows0),
    .HOLD(hold0), .ABORT(abort0), .BUSY(busy0), .DONE(done0),
    .CLR_ACC(clr0), .MAC_EN(en0), .SEQ_A(seqa0), .SEQ_B(seqb0),
    .WR_ROW(wr0), .ROW_IDX(row0)
  );

  mat_seq_ctrl #(.N(16), .MAC_LAT(0)) dut1 (
    .CLK(CLK), .RST(rst1), .START(start1), .ROWS(rows1),
    .HOLD(hold1), .ABORT(abort1), .BUSY(busy1), .DONE(done1),
    .CLR_ACC(clr1), .MAC_EN(en1), .SEQ_A(seqa1), .SEQ_B(seqb1),
    .WR_ROW(wr1), .ROW_IDX(row1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1; rst1 = 1;
    tick(); tick();
    rst0 = 0; rst1 = 0;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if ({busy0, done0, clr0, en0, wr0, seqa0, seqb0, row0} !== 17'd0) begin
        n_fail++;
        $display("FAIL reset0 got %b want 0",
          {busy0, done0, clr0, en0, wr0, seqa0, seqb0, row0});
      end
      n_checks++;
      if ({busy1, done1, clr1, en1, wr1, seqa1, seqb1, row1} !== 17'd0) begin
        n_fail++;
        $display("FAIL reset1 got %b want 0",
          {busy1, done1, clr1, en1, wr1, seqa1, seqb1, row1});
      end
      tick();
    end
  endtask

  task automatic test_single_row();
    logic [4:0] e;
    logic [3:0] es;
    start0 = 1; rows0 = 4'd0;
    tick();
    start0 = 0;
    for (int c = 1; c <= 23; c++) begin
      e = {c == 1, c >= 2 && c <= 17, c == 20, c == 21, c <= 21};
      es = (c >= 2 && c <= 17) ? 4'(c - 2) : 4'd0;
      n_checks++;
      if ({clr0, en0, wr0, done0, busy0} !== e || row0 !== 4'd0) begin
        n_fail++;
        $display("FAIL single_row ctl c=%0d got %b row %0d want %b row 0",
          c, {clr0, en0, wr0, done0, busy0}, row0, e);
      end
      if ((c >= 2 && c <= 17) || c >= 22) begin
        n_checks++;
        if (seqa0 !== es || seqb0 !== es) begin
          n_fail++;
          $display("FAIL single_row seq c=%0d got %0d/%0d want %0d",
            c, seqa0, seqb0, es);
        end
      end
      tick();
    end
  endtask

  task automatic test_full();
    int wr_cnt = 0;
    int done_at = -1;
    start0 = 1; rows0 = 4'd15;
    tick();
    start0 = 0;
    for (int c = 1; c <= 323; c++) begin
      if (wr0) begin
        wr_cnt++;
        n_checks++;
        if (c % 20 != 0 || c > 320 || row0 !== 4'(c / 20 - 1)) begin
          n_fail++;
          $display("FAIL full wr c=%0d row %0d want multiple of 20 row %0d",
            c, row0, c / 20 - 1);
        end
      end
      if (done0 && done_at < 0) done_at = c;
      if (c == 321 || c == 322) begin
        n_checks++;
        if (busy0 !== (c == 321)) begin
          n_fail++;
          $display("FAIL full busy c=%0d got %b want %b", c, busy0, c == 321);
        end
      end
      tick();
    end
    n_checks++;
    if (wr_cnt != 16 || done_at != 321) begin
      n_fail++;
      $display("FAIL full count got wr %0d done %0d want wr 16 done 321",
        wr_cnt, done_at);
    end
  endtask

  task automatic test_hold();
    logic [4:0] e;
    logic [3:0] es;
    int en_cnt = 0;
    start0 = 1; rows0 = 4'd0;
    tick();
    start0 = 0;
    for (int c = 1; c <= 28; c++) begin
      e = {c == 1, (c >= 2 && c <= 9) || (c >= 15 && c <= 22),
           c == 25, c == 26, c <= 26};
      es = (c <= 9) ? 4'(c - 2) : (c <= 14) ? 4'd7 : 4'(c - 7);
      if (en0) en_cnt++;
      n_checks++;
      if ({clr0, en0, wr0, done0, busy0} !== e) begin
        n_fail++;
        $display("FAIL hold ctl c=%0d got %b want %b",
          c, {clr0, en0, wr0, done0, busy0}, e);
      end
      if (c >= 2 && c <= 22) begin
        n_checks++;
        if (seqa0 !== es || seqb0 !== es) begin
          n_fail++;
          $display("FAIL hold seq c=%0d got %0d/%0d want %0d",
            c, seqa0, seqb0, es);
        end
      end
      hold0 = (c == 1) || (c >= 9 && c <= 13) || (c >= 23 && c <= 25);
      tick();
    end
    hold0 = 0;
    n_checks++;
    if (en_cnt != 16) begin
      n_fail++;
      $display("FAIL hold mac_count got %0d want 16", en_cnt);
    end
  endtask

  task automatic test_abort();
    logic [2:0] e;
    start0 = 1; rows0 = 4'd15;
    tick();
    start0 = 0;
    for (int c = 1; c <= 84; c++) begin
      e = {c == 20 || c == 60 || c == 80, c == 81,
           (c <= 30) || (c >= 41 && c <= 81)};
      n_checks++;
      if ({wr0, done0, busy0} !== e) begin
        n_fail++;
        $display("FAIL abort ctl c=%0d got %b want %b",
          c, {wr0, done0, busy0}, e);
      end
      if (c == 31) begin
        n_checks++;
        if ({clr0, en0, seqa0, row0} !== 10'd0) begin
          n_fail++;
          $display("FAIL abort idle c=31 got %b want 0",
            {clr0, en0, seqa0, row0});
        end
      end
      if (c == 80) begin
        n_checks++;
        if (row0 !== 4'd1) begin
          n_fail++;
          $display("FAIL abort row c=80 got %0d want 1", row0);
        end
      end
      abort0 = (c == 30);
      start0 = (c == 40);
      if (c == 40) rows0 = 4'd1;
      tick();
    end
  endtask

  task automatic test_start_busy();
    logic [2:0] e;
    start0 = 1; rows0 = 4'd7;
    tick();
    start0 = 0;
    for (int c = 1; c <= 166; c++) begin
      e = {c % 20 == 0 && c <= 160, c == 161, c <= 161};
      n_checks++;
      if ({wr0, done0, busy0} !== e) begin
        n_fail++;
        $display("FAIL start_busy ctl c=%0d got %b want %b",
          c, {wr0, done0, busy0}, e);
      end
      if (wr0) begin
        n_checks++;
        if (row0 !== 4'(c / 20 - 1)) begin
          n_fail++;
          $display("FAIL start_busy row c=%0d got %0d want %0d",
            c, row0, c / 20 - 1);
        end
      end
      start0 = (c == 100);
      rows0 = (c == 100) ? 4'd3 : 4'd7;
      tick();
    end
  endtask

  task automatic test_idle_abort();
    start0 = 1; abort0 = 1; rows0 = 4'd2;
    tick();
    start0 = 0; abort0 = 0;
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if ({busy0, clr0, en0} !== 3'd0) begin
        n_fail++;
        $display("FAIL idle_abort c=%0d got %b want 000",
          c, {busy0, clr0, en0});
      end
      abort0 = (c == 1);
      tick();
    end
    abort0 = 0;
  endtask

  task automatic test_reset_midrun();
    start0 = 1; rows0 = 4'd15;
    tick();
    start0 = 0;
    for (int c = 1; c <= 28; c++) begin
      if (c == 26 || c == 27) begin
        n_checks++;
        if ({busy0, done0, clr0, en0, wr0, seqa0, seqb0, row0} !== 17'd0) begin
          n_fail++;
          $display("FAIL reset_midrun c=%0d got %b want 0",
            c, {busy0, done0, clr0, en0, wr0, seqa0, seqb0, row0});
        end
      end
      rst0 = (c == 25);
      start0 = (c == 25);
      abort0 = (c == 25);
      hold0 = (c == 25);
      tick();
    end
    rst0 = 0; start0 = 0; abort0 = 0; hold0 = 0;
  endtask

  task automatic test_lat0();
    logic [4:0] e;
    logic [3:0] es;
    int rel, m;
    start1 = 1; rows1 = 4'd3;
    tick();
    start1 = 0;
    for (int c = 1; c <= 50; c++) begin
      es = 4'd0;
      if (c <= 10) begin
        e = {c == 1, c >= 2, 1'b0, 1'b0, 1'b1};
        if (c >= 2) es = 4'(c - 2);
      end else if (c == 11) begin
        e = 5'd0;
      end else begin
        rel = c - 11;
        m = (rel - 1) % 18;
        if (rel <= 36) begin
          e = {m == 0, m >= 1 && m <= 16, m == 17, 1'b0, 1'b1};
          if (m >= 1 && m <= 16) es = 4'(m - 1);
        end else begin
          e = {1'b0, 1'b0, 1'b0, rel == 37, rel == 37};
        end
      end
      n_checks++;
      if ({clr1, en1, wr1, done1, busy1} !== e || seqa1 !== es || seqb1 !== es) begin
        n_fail++;
        $display("FAIL lat0 c=%0d got %b seq %0d/%0d want %b seq %0d",
          c, {clr1, en1, wr1, done1, busy1}, seqa1, seqb1, e, es);
      end
      if (c == 11 || wr1) begin
        n_checks++;
        if (row1 !== ((c == 47) ? 4'd1 : 4'd0)) begin
          n_fail++;
          $display("FAIL lat0 row c=%0d got %0d", c, row1);
        end
      end
      rst1 = (c == 10);
      start1 = (c == 11);
      rows1 = (c == 11) ? 4'd1 : 4'd3;
      tick();
    end
  endtask

  initial begin
    rst0 = 0; start0 = 0; hold0 = 0; abort0 = 0; rows0 = 4'd0;
    rst1 = 0; start1 = 0; hold1 = 0; abort1 = 0; rows1 = 4'd0;
    tick();
    test_reset();
    test_single_row();
    tick();
    test_full();
    tick();
    test_hold();
    tick();
    test_abort();
    tick();
    test_start_busy();
    tick();
    test_idle_abort();
    tick();
    test_reset_midrun();
    tick();
    test_lat0();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_seq_ctrl.md
MAT_SEQ_CTRL -- requirements
Module: mat_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, meaning PE count, row length and number of k-steps per row.
REQ-002 SHALL have parameter LogN, default $clog2(N), meaning width of all index ports.
REQ-003 SHALL have parameter MAC_LAT, default 2, meaning PE MAC pipeline depth in cycles; legal range 0..7.
REQ-004 SHALL have port CLK, input, 1, meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port RST, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port START, input, 1, meaning run request, sampled only in IDLE.
REQ-007 SHALL have port ROWS, input, LogN, meaning last row index (rows-1), latched on accepted START.
REQ-008 SHALL have port HOLD, input, 1, meaning operand stall from the fetch path.
REQ-009 SHALL have port ABORT, input, 1, meaning cancel the current run.
REQ-010 SHALL have port BUSY, output, 1, meaning the state is not IDLE.
REQ-011 SHALL have port DONE, output, 1, meaning a one-cycle pulse at the end of the run.
REQ-012 SHALL have port CLR_ACC, output, 1, meaning clear the PE accumulators.
REQ-013 SHALL have port MAC_EN, output, 1, meaning the PEs accumulate this cycle.
REQ-014 SHALL have ports SEQ_A and SEQ_B, output, LogN each, meaning the k operand index into the A and B register files.
REQ-015 SHALL have port WR_ROW, output, 1, meaning write the PE results to the result row.
REQ-016 SHALL have port ROW_IDX, output, LogN, meaning the current output row r.

Function
REQ-017 SHALL implement states IDLE, CLEAR, MAC, DRAIN, WRITE, FIN, encoded via the package enum.
REQ-018 SHALL register all outputs as Moore outputs decoded from the state and counters.
REQ-019 IDLE: START=1 SHALL latch ROWS, set r=0 and enter CLEAR next cycle; START=0 SHALL stay in IDLE.
REQ-020 CLEAR: SHALL assert CLR_ACC for exactly 1 cycle, set k=0, then go to MAC.
REQ-021 MAC: SHALL assert MAC_EN=1 with SEQ_A=SEQ_B=k for each k=0..N-1 in order.
REQ-022 MAC: after k=N-1 SHALL go to DRAIN, or to WRITE directly when MAC_LAT=0.
REQ-023 MAC with HOLD=1: SHALL drive MAC_EN=0, freeze k and hold SEQ_A/SEQ_B; there is no limit on HOLD length.
REQ-024 HOLD SHALL have no effect in CLEAR, DRAIN, WRITE or FIN.
REQ-025 DRAIN: SHALL wait exactly MAC_LAT cycles using a drain counter, then go to WRITE.
REQ-026 WRITE: SHALL assert WR_ROW for 1 cycle with ROW_IDX=r.
REQ-027 WRITE: if r < latched ROWS, SHALL set r=r+1 and go to CLEAR; if r == ROWS, SHALL go to FIN.
REQ-028 FIN: SHALL assert DONE for 1 cycle, then go to IDLE.
REQ-029 Row period without HOLD SHALL be R = N+MAC_LAT+2 cycles.
REQ-030 With START accepted at cycle 0 and no HOLD, the last WR_ROW SHALL occur at cycle (ROWS+1)*R and DONE at (ROWS+1)*R+1.
REQ-031 START while BUSY SHALL be ignored, with no queuing; a changing ROWS input during a run SHALL have no effect.
REQ-032 ABORT=1 in any non-IDLE state SHALL force IDLE next cycle with no DONE and no WR_ROW; ABORT SHALL have priority over HOLD and state transitions.
REQ-033 ABORT in IDLE SHALL be ignored; START and ABORT together in IDLE SHALL leave the block in IDLE.
REQ-034 k, r and the drain counter SHALL wrap-free: k never exceeds N-1 and r never exceeds ROWS.
REQ-035 In IDLE, SEQ_A, SEQ_B and ROW_IDX SHALL be 0; CLR_ACC, MAC_EN and WR_ROW SHALL be 0 in any state not listed above.
REQ-036 BUSY SHALL be 1 from the cycle after accepted START through the FIN cycle inclusive.

Reset
REQ-037 RST=1 at a clock edge SHALL force IDLE, zero all counters and latched ROWS, and drive every output to 0 on the following cycle, including mid-run.
REQ-038 RST SHALL have priority over ABORT, START and HOLD.

Structure
REQ-039 SHALL take the state enum (seq_state_t) and MAC_LAT default from the shared package mat_seq_pkg.
REQ-040 SHALL be a single module with no sub-module; the counters are inline.

Verification
REQ-041 Verification SHALL cover: N=16, MAC_LAT=2, ROWS=15, START at cycle 0 -> 16 WR_ROW pulses at cycles 20,40,...,320 with ROW_IDX 0..15, DONE at 321, BUSY low at 322.
REQ-042 Verification SHALL cover: ROWS=0 -> single row; CLR_ACC at cycle 1; MAC_EN cycles 2..17 with SEQ_A 0..15; WR_ROW at 20; DONE at 21.
REQ-043 Verification SHALL cover: HOLD high 5 cycles while k=7 -> MAC_EN low for those cycles, SEQ_A stays 7, and DONE is delayed by exactly 5 cycles.
REQ-044 Verification SHALL cover: ABORT at cycle 30 of a full run -> IDLE at 31, no further WR_ROW, no DONE; a new START at 40 runs a complete new sequence.
REQ-045 Verification SHALL cover: START pulsed at cycle 100 while BUSY with ROWS=3 -> ignored, the original run completes unchanged.
REQ-046 Verification SHALL cover: MAC_LAT=0 and RST at cycle 10 -> R=18; after reset all outputs 0, state IDLE, and START is accepted on the next cycle.
